keypad_event_ctrl: RTL and testbench
====================================

# keypad_event_ctrl

Sequencer between the 4x5 matrix keypad scanner and the game logic. It converts the scanner's level-valued key code and debounced ready flag into discrete press, repeat and release events. Events are queued in a 4-entry FIFO and popped by the consumer through a valid/pop handshake. Typematic auto-repeat is optional.

## Interface
Parameters:
- HOLD_CYCLES, 50_000_000: cycles a key is held before the first repeat event (0.5 s at 100 MHz); must be ≥2.
- REPEAT_CYCLES, 10_000_000: cycles between successive repeat events; must be ≥2.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- key_code  in  5  scanner code; [4:2] row, [1:0] column; meaningful only while key_ready=1.
- key_ready  in  1  debounced "exactly one key down" flag from the scanner.
- ev_pop  in  1  consumer pops the FIFO head; acted on only when ev_valid=1.
- ovf_clr  in  1  clears the overflow flag.
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  5  key code of the FIFO head.
- ev_type  out  2  FIFO head type: 00 press, 01 repeat, 10 release; 11 never produced.
- ev_count  out  3  FIFO occupancy, 0..4.
- overflow  out  1  sticky; an event was dropped.
- key_held  out  1  a key is currently tracked (state ≠ IDLE).

## Operation
- Registers: cur_code (5 b), 32-bit tick counter, FSM state, 4x7-bit FIFO with 2-bit read/write pointers and a 3-bit count.
- FSM states: IDLE, PRESSED, REPEAT.
- IDLE with key_ready=1: push {key_code, press}, latch cur_code, clear counter, go to PRESSED.
- PRESSED or REPEAT with key_ready=0: push {cur_code, release}, go to IDLE.
- PRESSED or REPEAT with key_ready=1 and key_code≠cur_code: push {cur_code, release}, go to IDLE. The new key is pressed on the next cycle if key_ready is still 1.
- PRESSED with the same key: counter increments. At HOLD_CYCLES-1, push {cur_code, repeat}, clear counter, go to REPEAT.
- REPEAT with the same key: counter increments. At REPEAT_CYCLES-1, push {cur_code, repeat} and clear counter.
- At most one push per cycle.
- FIFO is first-word-fall-through: ev_code and ev_type always show the head entry.
- Pop occurs when ev_valid & ev_pop. Pop while empty is ignored.
- Push while count=4 without a same-cycle pop: the new event is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop in the same cycle at count=4: both are performed, count stays 4, overflow is not set.
- Push and pop in the same cycle at count=0: the pop is ignored and the push lands, so count becomes 1.
- Pointers wrap modulo 4.
- ovf_clr clears overflow. If ovf_clr coincides with a dropping push, overflow stays set (set wins).

## Timing
- All outputs are registered or decoded from registers. No combinational path from inputs to outputs.
- Latency: an input transition sampled at edge N produces ev_valid, ev_code and ev_type at edge N (visible in the cycle after N) when the FIFO was empty.
- Pop at edge N: the next head is visible after N, and ev_count decrements at N.
- First repeat comes exactly HOLD_CYCLES cycles after the press push. Later repeats come every REPEAT_CYCLES cycles.
- On rst assertion, immediately and regardless of clk:
  - state=IDLE; counter, pointers, cur_code=0
  - ev_valid=0, ev_code=0, ev_type=00, ev_count=0, overflow=0, key_held=0
- Reset mid-hold emits no release event. If key_ready=1 after reset deasserts, a fresh press is generated.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined: full behaviour as above, with the REPEAT state and the counter.
- KEYPAD_AUTOREPEAT_EN undefined:
  - FSM reduces to IDLE/PRESSED; the counter is not built.
  - Type 01 is never produced; HOLD_CYCLES and REPEAT_CYCLES are ignored.
  - Press, release, code-change and FIFO behaviour are identical to the defined case.

## Test plan
Benches use HOLD_CYCLES=8, REPEAT_CYCLES=4, and KEYPAD_AUTOREPEAT_EN defined unless noted.
- Hold key_code=5'h06 with key_ready=1 for 3 cycles, then drop key_ready -> FIFO holds {06,press},{06,release}; ev_count=2; popping twice returns them in that order, then ev_valid=0.
- Hold 5'h06 for 20 cycles, popping every cycle -> press at t0, repeats at t0+8, t0+12, t0+16, release after the drop. Same stimulus with the macro undefined -> press and release only.
- Generate 5 events with no pop -> ev_count=4, overflow=1, head still the first press; pulse ovf_clr -> overflow=0.
- At count=4, present a release push with ev_pop=1 in the same cycle -> ev_count stays 4, overflow=0, newest entry is the release.
- Change key_code from 06 to 0B with key_ready held at 1 -> {06,release} then {0B,press} on consecutive cycles; key_held stays 1 except for one IDLE cycle.
- Assert rst asynchronously mid-REPEAT with 3 events queued -> all outputs 0 before the next clk edge; after release, with key_ready=1 still held, a single {code,press} is generated.

Source files
------------

// File: rtl/keypad_event_ctrl_if.sv
// keypad_event_ctrl_if
//
// Bundles the scanner inputs, the consumer handshake and the event FIFO status
// of keypad_event_ctrl.
//
// Signals:
//   key_code  [4:0]  scanner code, [4:2] row, [1:0] column
//   key_ready        debounced "exactly one key down" flag
//   ev_pop           consumer pops the FIFO head (ignored while ev_valid=0)
//   ovf_clr          clears the sticky overflow flag
//   ev_valid         FIFO non-empty
//   ev_code   [4:0]  key code of the FIFO head
//   ev_type   [1:0]  head type: 00 press, 01 repeat, 10 release
//   ev_count  [2:0]  FIFO occupancy, 0..4
//   overflow         sticky, an event was dropped
//   key_held         a key is currently tracked
//
// Modports: slave is the controller, master is the scanner/consumer side.
interface keypad_event_ctrl_if;
    logic [4:0] key_code;
    logic       key_ready;
    logic       ev_pop;
    logic       ovf_clr;
    logic       ev_valid;
    logic [4:0] ev_code;
    logic [1:0] ev_type;
    logic [2:0] ev_count;
    logic       overflow;
    logic       key_held;

    modport slave (
        input  key_code, key_ready, ev_pop, ovf_clr,
        output ev_valid, ev_code, ev_type, ev_count, overflow, key_held
    );

    modport master (
        output key_code, key_ready, ev_pop, ovf_clr,
        input  ev_valid, ev_code, ev_type, ev_count, overflow, key_held
    );
endinterface

// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl
//
// Turns the keypad scanner's level-valued code/ready pair into discrete press,
// repeat and release events, queued in a 4-entry first-word-fall-through FIFO
// that the consumer drains with a valid/pop handshake.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  keypad_event_ctrl_if.slave (scanner inputs, pop/ovf_clr, FIFO outputs)
//
// Parameters:
//   HOLD_CYCLES    cycles from the press event to the first repeat (>= 2)
//   REPEAT_CYCLES  cycles between successive repeats (>= 2)
//
// Configuration macro:
//   KEYPAD_AUTOREPEAT_EN  when defined, builds the REPEAT state and the hold
//                         counter; otherwise only press/release are produced
//                         and both parameters are ignored.
module keypad_event_ctrl #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input logic                clk,
    input logic                rst,
    keypad_event_ctrl_if.slave bus
);

    localparam logic [1:0] TypePress   = 2'b00;
    localparam logic [1:0] TypeRepeat  = 2'b01;
    localparam logic [1:0] TypeRelease = 2'b10;

`ifdef KEYPAD_AUTOREPEAT_EN
    typedef enum logic [1:0] {StIdle, StPressed, StRepeat} state_t;
`else
    typedef enum logic {StIdle, StPressed} state_t;
`endif

    state_t     state_q, state_d;
    logic [4:0] cur_code_q, cur_code_d;

    // Event request from the FSM, at most one per cycle
    logic       push;
    logic [4:0] push_code;
    logic [1:0] push_type;

`ifdef KEYPAD_AUTOREPEAT_EN
    logic [31:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES, TypeRepeat};
`endif

    // ------------------------------------------------------------------
    // Key tracking FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        push       = 1'b0;
        push_code  = cur_code_q;
        push_type  = TypePress;
`ifdef KEYPAD_AUTOREPEAT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.key_ready) begin
                    push       = 1'b1;
                    push_code  = bus.key_code;
                    push_type  = TypePress;
                    cur_code_d = bus.key_code;
                    state_d    = StPressed;
`ifdef KEYPAD_AUTOREPEAT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StPressed: begin
                // A different key counts as a release; the new key is pressed
                // from IDLE on the following cycle.
                if (!bus.key_ready || (bus.key_code != cur_code_q)) begin
                    push      = 1'b1;
                    push_type = TypeRelease;
                    state_d   = StIdle;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (cnt_q == HOLD_CYCLES - 1) begin
                    push      = 1'b1;
                    push_type = TypeRepeat;
                    cnt_d     = '0;
                    state_d   = StRepeat;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            StRepeat: begin
                if (!bus.key_ready || (bus.key_code != cur_code_q)) begin
                    push      = 1'b1;
                    push_type = TypeRelease;
                    state_d   = StIdle;
                end else if (cnt_q == REPEAT_CYCLES - 1) begin
                    push      = 1'b1;
                    push_type = TypeRepeat;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
`endif
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_code_q <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_code_q <= cur_code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [6:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q, count_d;
    logic       overflow_q, overflow_d;
    logic       do_pop, do_push, drop;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_pop  = (count_q != 3'd0) && bus.ev_pop;
    assign do_push = push && ((count_q != 3'd4) || do_pop);
    assign drop    = push && (count_q == 3'd4) && !do_pop;
    assign count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_q[wr_ptr_q] <= {push_code, push_type};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.ev_valid = (count_q != 3'd0);
    assign bus.ev_code  = fifo_q[rd_ptr_q][6:2];
    assign bus.ev_type  = fifo_q[rd_ptr_q][1:0];
    assign bus.ev_count = count_q;
    assign bus.overflow = overflow_q;
    assign bus.key_held = (state_q != StIdle);

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// tb_keypad_event_ctrl
//
// Directed self-checking bench for keypad_event_ctrl with HOLD_CYCLES=8 and
// REPEAT_CYCLES=4. Expected values are hand-derived; repeat expectations
// follow KEYPAD_AUTOREPEAT_EN.
module tb_keypad_event_ctrl;

    localparam int unsigned Hold = 8;
    localparam int unsigned Rep  = 4;

    localparam logic [1:0] TPress   = 2'b00;
    localparam logic [1:0] TRepeat  = 2'b01;
    localparam logic [1:0] TRelease = 2'b10;

    logic clk = 1'b0;
    logic rst;

    keypad_event_ctrl_if bus ();

    keypad_event_ctrl #(
        .HOLD_CYCLES  (Hold),
        .REPEAT_CYCLES(Rep)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [4:0] code, input logic [1:0] typ);
        check({tag, ".valid"}, 32'(bus.ev_valid), 32'd1);
        check({tag, ".code"}, 32'(bus.ev_code), 32'(code));
        check({tag, ".type"}, 32'(bus.ev_type), 32'(typ));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, 32'(bus.ev_valid), 32'd0);
        check({tag, ".code"}, 32'(bus.ev_code), 32'd0);
        check({tag, ".type"}, 32'(bus.ev_type), 32'd0);
        check({tag, ".count"}, 32'(bus.ev_count), 32'd0);
        check({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
        check({tag, ".held"}, 32'(bus.key_held), 32'd0);
    endtask

    int         ev_cyc[$];
    logic [6:0] ev_dat[$];
    int         exp_cyc[$];
    logic [6:0] exp_dat[$];

    initial begin
        rst           = 1'b1;
        bus.key_code  = '0;
        bus.key_ready = 1'b0;
        bus.ev_pop    = 1'b0;
        bus.ovf_clr   = 1'b0;
        #22;
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Short hold then release: press and release queued in order
        bus.key_code  = 5'h06;
        bus.key_ready = 1'b1;
        step();
        check("t1.latency_count", 32'(bus.ev_count), 32'd1);
        check_head("t1.latency_head", 5'h06, TPress);
        check("t1.held", 32'(bus.key_held), 32'd1);
        step();
        step();
        bus.key_ready = 1'b0;
        step();
        check("t1.count", 32'(bus.ev_count), 32'd2);
        check("t1.held_after", 32'(bus.key_held), 32'd0);
        check_head("t1.head0", 5'h06, TPress);
        bus.ev_pop = 1'b1;
        step();
        check_head("t1.head1", 5'h06, TRelease);
        check("t1.count1", 32'(bus.ev_count), 32'd1);
        step();
        check("t1.empty", 32'(bus.ev_valid), 32'd0);
        check("t1.count0", 32'(bus.ev_count), 32'd0);
        bus.ev_pop = 1'b0;

        // Long hold with continuous pop: event timeline
        bus.ev_pop    = 1'b1;
        bus.key_code  = 5'h06;
        bus.key_ready = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            if (i == 21) bus.key_ready = 1'b0;
            step();
            if (bus.ev_valid) begin
                ev_cyc.push_back(i);
                ev_dat.push_back({bus.ev_code, bus.ev_type});
            end
        end
        bus.ev_pop = 1'b0;
        exp_cyc.push_back(1);
        exp_dat.push_back({5'h06, TPress});
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_cyc.push_back(9);
        exp_dat.push_back({5'h06, TRepeat});
        exp_cyc.push_back(13);
        exp_dat.push_back({5'h06, TRepeat});
        exp_cyc.push_back(17);
        exp_dat.push_back({5'h06, TRepeat});
`endif
        exp_cyc.push_back(21);
        exp_dat.push_back({5'h06, TRelease});
        check("t2.num_events", 32'(ev_cyc.size()), 32'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < ev_cyc.size(); i++) begin
            check($sformatf("t2.ev%0d.cycle", i), 32'(ev_cyc[i]), 32'(exp_cyc[i]));
            check($sformatf("t2.ev%0d.data", i), 32'(ev_dat[i]), 32'(exp_dat[i]));
        end
        check("t2.empty", 32'(bus.ev_count), 32'd0);

        // Five events without popping: fifth is dropped
        bus.key_code = 5'h06; bus.key_ready = 1'b1; step();
        bus.key_ready = 1'b0; step();
        bus.key_code = 5'h0B; bus.key_ready = 1'b1; step();
        bus.key_ready = 1'b0; step();
        bus.key_code = 5'h06; bus.key_ready = 1'b1; step();
        check("t3.count", 32'(bus.ev_count), 32'd4);
        check("t3.ovf", 32'(bus.overflow), 32'd1);
        check_head("t3.head", 5'h06, TPress);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("t3.ovf_clr", 32'(bus.overflow), 32'd0);
        check("t3.count_kept", 32'(bus.ev_count), 32'd4);

        // Full FIFO, release push with simultaneous pop
        bus.key_ready = 1'b0;
        bus.ev_pop    = 1'b1;
        step();
        bus.ev_pop = 1'b0;
        check("t4.count", 32'(bus.ev_count), 32'd4);
        check("t4.ovf", 32'(bus.overflow), 32'd0);
        check_head("t4.h0", 5'h06, TRelease);
        bus.ev_pop = 1'b1;
        step();
        check_head("t4.h1", 5'h0B, TPress);
        step();
        check_head("t4.h2", 5'h0B, TRelease);
        step();
        check_head("t4.h3_newest", 5'h06, TRelease);
        step();
        bus.ev_pop = 1'b0;
        check("t4.empty", 32'(bus.ev_count), 32'd0);

        // Code change while ready stays high
        bus.key_code  = 5'h06;
        bus.key_ready = 1'b1;
        step();
        check("t5.held_a", 32'(bus.key_held), 32'd1);
        bus.key_code = 5'h0B;
        step();
        check("t5.held_idle", 32'(bus.key_held), 32'd0);
        step();
        check("t5.held_b", 32'(bus.key_held), 32'd1);
        check("t5.count", 32'(bus.ev_count), 32'd3);
        bus.ev_pop = 1'b1;
        check_head("t5.h0", 5'h06, TPress);
        step();
        check_head("t5.h1", 5'h06, TRelease);
        step();
        check_head("t5.h2", 5'h0B, TPress);
        step();
        check("t5.empty", 32'(bus.ev_count), 32'd0);
        bus.key_ready = 1'b0;
        step();
        check_head("t5.rel", 5'h0B, TRelease);
        step();
        bus.ev_pop = 1'b0;
        check("t5.empty2", 32'(bus.ev_count), 32'd0);

        // Async reset mid-hold
        bus.key_code  = 5'h06;
        bus.key_ready = 1'b1;
        for (int i = 0; i < 13; i++) step();
`ifdef KEYPAD_AUTOREPEAT_EN
        check("t6.queued", 32'(bus.ev_count), 32'd3);
`else
        check("t6.queued", 32'(bus.ev_count), 32'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t6.async");
        step();
        #2;
        rst = 1'b0;
        step();
        check("t6.count", 32'(bus.ev_count), 32'd1);
        check_head("t6.press", 5'h06, TPress);
        check("t6.held", 32'(bus.key_held), 32'd1);
        step();
        step();
        check("t6.single", 32'(bus.ev_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
